sma_level_detect: RTL and testbench
===================================

Name: sma_level_detect

Overview:
- Downstream consumer of the moving-average filter output.
- Applies a hysteresis comparator with sample-count debounce to the smoothed stream.
- Emits a registered level flag, one-cycle rise/fall event pulses, and the peak value seen during each confirmed high episode.
- Feeds the event/interrupt logic.

Parameters:
- DATA_INPUT_WIDTH, 16: width of input samples, thresholds and peak_data.
- DEBOUNCE_SAMPLES, 3: consecutive qualifying valid samples needed to confirm a transition. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_INPUT_WIDTH  smoothed sample from the averaging filter (unsigned).
- in_data_valid  input  1  qualifies in_data; one sample per high cycle.
- thresh_hi  input  DATA_INPUT_WIDTH  rise threshold (unsigned), sampled with each valid sample.
- thresh_lo  input  DATA_INPUT_WIDTH  fall threshold (unsigned), sampled with each valid sample.
- level_out  output  1  registered debounced level; 1 = HIGH or FALL_PEND.
- rise_pulse  output  1  one-cycle pulse on confirmed rise.
- fall_pulse  output  1  one-cycle pulse on confirmed fall.
- peak_data  output  DATA_INPUT_WIDTH  max sample of the last completed high episode; held until the next update.
- peak_valid  output  1  one-cycle pulse when peak_data updates.

Behaviour:
- Reset:
  - Asynchronous, active-high (rst) on clk.
  - State = LOW, debounce count = 0, running peak = 0.
  - level_out, rise_pulse, fall_pulse, peak_valid, peak_data = 0.
  - Reset mid-episode discards the pending count and running peak; no pulses are emitted.
- Only cycles with in_data_valid = 1 advance state, count or peak. Invalid cycles hold everything; pulses still self-clear.
- Compares are unsigned:
  - "above" = in_data > thresh_hi.
  - "below" = in_data < thresh_lo.
  - Thresholds are applied literally, including when thresh_lo > thresh_hi; there is no error check.
- FSM states are LOW, RISE_PEND, HIGH, FALL_PEND.
- LOW:
  - On an above sample: count = 1, running peak = in_data, go to RISE_PEND.
  - If DEBOUNCE_SAMPLES == 1, go directly to HIGH with rise_pulse.
  - Otherwise stay.
- RISE_PEND:
  - Above sample: count+1 and peak = max(peak, in_data). When count reaches DEBOUNCE_SAMPLES, go to HIGH and pulse rise_pulse.
  - Non-above sample: count = 0, peak discarded, return to LOW, no pulse.
- HIGH:
  - Every valid sample updates peak = max(peak, in_data).
  - Below sample: count = 1, go to FALL_PEND. If DEBOUNCE_SAMPLES == 1, complete the fall immediately.
- FALL_PEND:
  - Below sample: count+1. When count reaches DEBOUNCE_SAMPLES, go to LOW and in the same cycle pulse fall_pulse and peak_valid, with peak_data = running peak.
  - Non-below sample: count = 0, return to HIGH, no pulse.
  - The peak still updates with every valid sample.
- Latency:
  - Outputs are registered. Pulses and level_out change on the clk edge that samples the qualifying valid sample, so they are visible the following cycle.
  - There is no combinational path from input to output.
- Count width is 8 bits. The count never exceeds DEBOUNCE_SAMPLES and never wraps.
- rise_pulse and fall_pulse are never high in the same cycle. Neither pulse is ever high for 2 consecutive cycles.

Test Plan (DEBOUNCE_SAMPLES=3, thresh_hi=100, thresh_lo=50):
- Rise: valid samples 0,120,130,140 -> rise_pulse high exactly 1 cycle after the 140 edge; level_out 0->1 in that cycle.
- Aborted rise: 120,130,90 -> no rise_pulse, level_out stays 0. Then 110,110,110 -> rise_pulse once.
- Fall with peak: after the rise, 200,150,40,30,20 -> after the 20 edge, fall_pulse=1, peak_valid=1, peak_data=200, level_out=0. peak_data still 200 ten cycles later.
- Valid gaps: 120, 5 idle cycles, 130, 3 idle cycles, 140 -> rise_pulse after 140. Idle cycles change nothing.
- Hysteresis band: in HIGH, samples 75,60,40,75,40,40,40 -> no fall after the first 40 (the 75 resets the count); fall_pulse after the third consecutive 40.
- Reset mid-operation: assert rst asynchronously while in FALL_PEND with count=2 -> all outputs 0 immediately. After release, 40 alone produces no pulse; a full rise is required.

Source files
------------

// File: rtl/sma_level_detect_if.sv
// Sample/threshold stream into the level detector and the debounced level,
// event pulses and episode peak coming back out.
interface sma_level_detect_if #(
  parameter int DATA_INPUT_WIDTH = 16
);
  logic [DATA_INPUT_WIDTH-1:0] in_data;
  logic                        in_data_valid;
  logic [DATA_INPUT_WIDTH-1:0] thresh_hi;
  logic [DATA_INPUT_WIDTH-1:0] thresh_lo;
  logic                        level_out;
  logic                        rise_pulse;
  logic                        fall_pulse;
  logic [DATA_INPUT_WIDTH-1:0] peak_data;
  logic                        peak_valid;

  // Producer side: the averaging filter plus whoever programs thresholds.
  modport master (
    output in_data, in_data_valid, thresh_hi, thresh_lo,
    input  level_out, rise_pulse, fall_pulse, peak_data, peak_valid
  );

  // Detector side.
  modport slave (
    input  in_data, in_data_valid, thresh_hi, thresh_lo,
    output level_out, rise_pulse, fall_pulse, peak_data, peak_valid
  );
endinterface

// File: rtl/sma_level_detect.sv
// Hysteresis comparator with sample-count debounce on a smoothed stream;
// registered level, rise/fall pulses and per-episode peak capture.
module sma_level_detect #(
  parameter int DATA_INPUT_WIDTH = 16,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input logic                clk,
  input logic                rst,
  sma_level_detect_if.slave  bus
);

  localparam logic [7:0] DEB_COUNT = 8'(DEBOUNCE_SAMPLES);
  localparam bit         ONE_SHOT  = (DEBOUNCE_SAMPLES == 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  state_t                      state_r, next_state_s;
  logic [7:0]                  count_r, count_s;
  logic [DATA_INPUT_WIDTH-1:0] peak_r, peak_s;
  logic                        level_r, level_s;
  logic                        rise_r, rise_s;
  logic                        fall_r, fall_s;
  logic                        pvalid_r, pvalid_s;
  logic [DATA_INPUT_WIDTH-1:0] pdata_r, pdata_s;

  logic                        above_s, below_s;
  logic [7:0]                  count_inc_s;
  logic [DATA_INPUT_WIDTH-1:0] peak_max_s;

  // Unsigned threshold compares and running-peak candidate for this sample.
  always_comb begin
    above_s     = (bus.in_data > bus.thresh_hi);
    below_s     = (bus.in_data < bus.thresh_lo);
    count_inc_s = count_r + 8'd1;
    peak_max_s  = (bus.in_data > peak_r) ? bus.in_data : peak_r;
  end

  // Next-state, debounce count, running peak and output pulse decode.
  always_comb begin
    next_state_s = state_r;
    count_s      = count_r;
    peak_s       = peak_r;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    pvalid_s     = 1'b0;
    pdata_s      = pdata_r;
    if (bus.in_data_valid) begin
      case (state_r)
        ST_LOW: begin
          if (above_s) begin
            peak_s = bus.in_data;
            if (ONE_SHOT) begin
              next_state_s = ST_HIGH;
              count_s      = 8'd0;
              rise_s       = 1'b1;
            end else begin
              next_state_s = ST_RISE_PEND;
              count_s      = 8'd1;
            end
          end else begin
            count_s = 8'd0;
          end
        end
        ST_RISE_PEND: begin
          if (above_s) begin
            peak_s = peak_max_s;
            if (count_inc_s == DEB_COUNT) begin
              next_state_s = ST_HIGH;
              count_s      = 8'd0;
              rise_s       = 1'b1;
            end else begin
              count_s = count_inc_s;
            end
          end else begin
            next_state_s = ST_LOW;
            count_s      = 8'd0;
            peak_s       = '0;
          end
        end
        ST_HIGH: begin
          peak_s = peak_max_s;
          if (below_s) begin
            if (ONE_SHOT) begin
              next_state_s = ST_LOW;
              count_s      = 8'd0;
              fall_s       = 1'b1;
              pvalid_s     = 1'b1;
              pdata_s      = peak_max_s;
              peak_s       = '0;
            end else begin
              next_state_s = ST_FALL_PEND;
              count_s      = 8'd1;
            end
          end else begin
            count_s = 8'd0;
          end
        end
        ST_FALL_PEND: begin
          peak_s = peak_max_s;
          if (below_s) begin
            if (count_inc_s == DEB_COUNT) begin
              // The completing sample itself still contributes to the peak.
              next_state_s = ST_LOW;
              count_s      = 8'd0;
              fall_s       = 1'b1;
              pvalid_s     = 1'b1;
              pdata_s      = peak_max_s;
              peak_s       = '0;
            end else begin
              count_s = count_inc_s;
            end
          end else begin
            next_state_s = ST_HIGH;
            count_s      = 8'd0;
          end
        end
        default: begin
          next_state_s = ST_LOW;
          count_s      = 8'd0;
          peak_s       = '0;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
    level_s = (next_state_s == ST_HIGH) || (next_state_s == ST_FALL_PEND);
  end

  // State, count, peak and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_LOW;
      count_r  <= 8'd0;
      peak_r   <= '0;
      level_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      pvalid_r <= 1'b0;
      pdata_r  <= '0;
    end else begin
      state_r  <= next_state_s;
      count_r  <= count_s;
      peak_r   <= peak_s;
      level_r  <= level_s;
      rise_r   <= rise_s;
      fall_r   <= fall_s;
      pvalid_r <= pvalid_s;
      pdata_r  <= pdata_s;
    end
  end

  assign bus.level_out  = level_r;
  assign bus.rise_pulse = rise_r;
  assign bus.fall_pulse = fall_r;
  assign bus.peak_valid = pvalid_r;
  assign bus.peak_data  = pdata_r;

endmodule

// File: tb/tb_sma_level_detect.sv
// Directed plus random bench for sma_level_detect, checked every cycle against
// a sample-history reference model.
module tb_sma_level_detect;

  localparam int W = 16;
  localparam int D = 3;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  sma_level_detect_if #(.DATA_INPUT_WIDTH(W)) bus ();

  sma_level_detect #(.DATA_INPUT_WIDTH(W), .DEBOUNCE_SAMPLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full history of valid samples since reset. A transition
  // is confirmed when the last D samples after the previous transition all
  // qualify; the episode peak is the max over samples from the rise streak on.
  bit          q_above[$];
  bit          q_below[$];
  logic [W-1:0] q_data[$];
  int          last_tr;
  int          ep_start;
  bit          m_level;
  logic        e_level, e_rise, e_fall, e_pv;
  logic [W-1:0] e_peak;

  function automatic void model_reset();
    q_above.delete();
    q_below.delete();
    q_data.delete();
    last_tr  = 0;
    ep_start = 0;
    m_level  = 1'b0;
    e_level  = 1'b0;
    e_rise   = 1'b0;
    e_fall   = 1'b0;
    e_pv     = 1'b0;
    e_peak   = '0;
  endfunction

  function automatic void model_step(bit valid, logic [W-1:0] d, logic [W-1:0] hi, logic [W-1:0] lo);
    int n;
    int run;
    logic [W-1:0] mx;
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_pv   = 1'b0;
    if (valid) begin
      q_data.push_back(d);
      q_above.push_back(d > hi);
      q_below.push_back(d < lo);
      n   = q_data.size();
      run = 0;
      for (int i = n - 1; i >= last_tr && run < D; i--) begin
        if (m_level ? q_below[i] : q_above[i]) run++;
        else break;
      end
      if (run == D) begin
        if (!m_level) begin
          m_level  = 1'b1;
          e_rise   = 1'b1;
          ep_start = n - D;
        end else begin
          mx = '0;
          for (int i = ep_start; i < n; i++) if (q_data[i] > mx) mx = q_data[i];
          m_level = 1'b0;
          e_fall  = 1'b1;
          e_pv    = 1'b1;
          e_peak  = mx;
        end
        last_tr = n;
      end
    end
    e_level = m_level;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    check({ctx, "/level"},      32'(bus.level_out),  32'(e_level));
    check({ctx, "/rise"},       32'(bus.rise_pulse), 32'(e_rise));
    check({ctx, "/fall"},       32'(bus.fall_pulse), 32'(e_fall));
    check({ctx, "/peak_valid"}, 32'(bus.peak_valid), 32'(e_pv));
    check({ctx, "/peak_data"},  32'(bus.peak_data),  32'(e_peak));
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs sampled 1 unit after the next.
  task automatic step(string ctx, bit valid, logic [W-1:0] d, logic [W-1:0] hi, logic [W-1:0] lo);
    bus.in_data_valid = valid;
    bus.in_data       = d;
    bus.thresh_hi     = hi;
    bus.thresh_lo     = lo;
    @(posedge clk);
    #1;
    model_step(valid, d, hi, lo);
    check_all(ctx);
  endtask

  task automatic vs(string ctx, logic [W-1:0] d);
    step(ctx, 1'b1, d, 16'd100, 16'd50);
  endtask

  task automatic idle(string ctx, int n);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 16'd0, 16'd100, 16'd50);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    bus.in_data_valid = 1'b0;
    bus.in_data       = '0;
    bus.thresh_hi     = 16'd100;
    bus.thresh_lo     = 16'd50;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Rise
    vs("rise", 16'd0); vs("rise", 16'd120); vs("rise", 16'd130); vs("rise", 16'd140);
    check("rise_seen", 32'(bus.rise_pulse), 32'd1);
    idle("rise_idle", 1);

    // Fall with peak, then hold
    vs("fall", 16'd200); vs("fall", 16'd150); vs("fall", 16'd40); vs("fall", 16'd30); vs("fall", 16'd20);
    check("fall_peak", 32'(bus.peak_data), 32'd200);
    idle("peak_hold", 10);
    check("peak_held", 32'(bus.peak_data), 32'd200);

    // Aborted rise, then a clean one
    vs("abort", 16'd120); vs("abort", 16'd130); vs("abort", 16'd90);
    vs("rise2", 16'd110); vs("rise2", 16'd110); vs("rise2", 16'd110);
    check("rise2_seen", 32'(bus.rise_pulse), 32'd1);

    // Hysteresis band inside HIGH
    vs("band", 16'd75); vs("band", 16'd60); vs("band", 16'd40); vs("band", 16'd75);
    vs("band", 16'd40); vs("band", 16'd40); vs("band", 16'd40);
    check("band_fall", 32'(bus.fall_pulse), 32'd1);
    check("band_peak", 32'(bus.peak_data), 32'd110);

    // Valid gaps
    vs("gap", 16'd120); idle("gap", 5); vs("gap", 16'd130); idle("gap", 3); vs("gap", 16'd140);
    check("gap_rise", 32'(bus.rise_pulse), 32'd1);

    // Asynchronous reset while FALL_PEND holds count=2
    vs("pre_rst", 16'd40); vs("pre_rst", 16'd30);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    vs("post_rst", 16'd40);
    vs("post_rst", 16'd120); vs("post_rst", 16'd130); vs("post_rst", 16'd140);
    check("post_rst_rise", 32'(bus.rise_pulse), 32'd1);
    vs("post_rst", 16'd40); vs("post_rst", 16'd40); vs("post_rst", 16'd40);

    // Random stream, occasionally with arbitrary (possibly inverted) thresholds
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] hi, lo;
      hi = 16'd100;
      lo = 16'd50;
      if ($urandom_range(0, 15) == 0) begin
        hi = 16'($urandom_range(0, 160));
        lo = 16'($urandom_range(0, 160));
      end
      step("rand", ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 160)), hi, lo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
